// File: rtl/seq_1to8_demux.sv
// seq_1to8_demux
//   Serial-to-parallel 1-to-8 demultiplexer. Each accepted serial bit is
//   steered into one of eight byte slots chosen by a 3-bit slot counter.
//   After eight bits the byte is presented on a valid/ready output. A
//   frame-gap timeout drops partial frames that stall too long.
//
//   Optional feature macro: DEMUX_PARITY_EN
//     When defined, every frame carries a 9th bit (even parity over the
//     8 data bits). A mismatching byte is dropped and frame_err pulses.
//
// Parameters
//   LSB_FIRST  1: first received bit lands in o[0]; 0: it lands in o[7]
//   TIMEOUT    idle cycles allowed between bits inside a frame; 0 disables
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   i          serial data bit
//   i_valid    i carries a bit this cycle
//   i_ready    block can accept a bit this cycle
//   o          assembled byte (registered, updated only on frame completion)
//   o_valid    o holds a complete byte
//   o_ready    downstream accepts o
//   s          current slot index (data bits accepted in the current frame)
//   frame_err  one-cycle pulse: frame discarded (timeout or parity error)
module seq_1to8_demux #(
   parameter int LSB_FIRST = 1,
   parameter int TIMEOUT   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i,
   input  logic       i_valid,
   output logic       i_ready,
   output logic [7:0] o,
   output logic       o_valid,
   input  logic       o_ready,
   output logic [2:0] s,
   output logic       frame_err
);

   // A zero TIMEOUT still needs a legal (1-bit) counter width.
   localparam int GAP_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = (TIMEOUT > 0) ? GAP_W'(TIMEOUT - 1) : '0;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef DEMUX_PARITY_EN
   localparam logic [1:0] ST_PARITY = 2'd2;
`endif
   localparam logic [1:0] ST_FULL   = 2'd3;

   logic [1:0]       state;
   logic [2:0]       cnt;
   logic [GAP_W-1:0] gap;
   logic [7:0]       asm_p0;
   logic [7:0]       asm_next;
   logic [2:0]       slot;
   logic             accept;

   // The idle cycle that would bring the gap count up to TIMEOUT is the
   // timeout event; an accepted bit in that same cycle takes priority.
   function automatic logic gap_expired(input logic [GAP_W-1:0] g);
      return (TIMEOUT > 0) && (g == GAP_LAST);
   endfunction

   // Saturating step: never counts when the timeout is disabled, and the
   // expiry check above keeps it from ever passing TIMEOUT-1.
   function automatic logic [GAP_W-1:0] gap_inc(input logic [GAP_W-1:0] g);
      return (TIMEOUT > 0) ? g + 1'b1 : g;
   endfunction

   assign o_valid = (state == ST_FULL);
   assign i_ready = (state != ST_FULL);
   assign s       = (state == ST_SHIFT) ? cnt : 3'd0;
   assign accept  = i_valid && i_ready;

   always_comb begin
      slot             = (LSB_FIRST != 0) ? cnt : (3'd7 - cnt);
      asm_next         = asm_p0;
      asm_next[slot]   = i;
   end

   // Stage p0: assembly register (data only, no reset needed).
   always_ff @(posedge clk) begin
      if (accept && ((state == ST_IDLE) || (state == ST_SHIFT)))
         asm_p0 <= asm_next;
   end

   // Control: frame FSM, slot counter, gap counter, output byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= 3'd0;
         gap       <= '0;
         o         <= 8'h00;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               gap <= '0;
               if (accept) begin
                  cnt   <= 3'd1;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (accept) begin
                  gap <= '0;
                  if (cnt == 3'd7) begin
                     cnt <= 3'd0;
`ifdef DEMUX_PARITY_EN
                     state <= ST_PARITY;
`else
                     state <= ST_FULL;
                     o     <= asm_next;
`endif
                  end else begin
                     cnt <= cnt + 3'd1;
                  end
               end else if (gap_expired(gap)) begin
                  state     <= ST_IDLE;
                  cnt       <= 3'd0;
                  gap       <= '0;
                  frame_err <= 1'b1;
               end else begin
                  gap <= gap_inc(gap);
               end
            end
`ifdef DEMUX_PARITY_EN
            ST_PARITY: begin
               if (accept) begin
                  gap <= '0;
                  // Even parity: the parity bit equals the XOR of the data.
                  if (i == ^asm_p0) begin
                     state <= ST_FULL;
                     o     <= asm_p0;
                  end else begin
                     state     <= ST_IDLE;
                     frame_err <= 1'b1;
                  end
               end else if (gap_expired(gap)) begin
                  state     <= ST_IDLE;
                  gap       <= '0;
                  frame_err <= 1'b1;
               end else begin
                  gap <= gap_inc(gap);
               end
            end
`endif
            ST_FULL: begin
               gap <= '0;
               if (o_ready)
                  state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= 3'd0;
               gap   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_1to8_demux.sv
// tb_seq_1to8_demux
//   Bench for seq_1to8_demux. Two instances share all inputs: one with
//   LSB_FIRST=1 and one with LSB_FIRST=0, both with TIMEOUT=4. A frame-level
//   reference model (bit queue + gap count) predicts every output.
//   Honors DEMUX_PARITY_EN when defined at compile time.
module tb_seq_1to8_demux;

   localparam int TO = 4;
`ifdef DEMUX_PARITY_EN
   localparam int FRAME = 9;
`else
   localparam int FRAME = 8;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i = 1'b0;
   logic       i_valid = 1'b0;
   logic       o_ready = 1'b1;
   logic       i_ready, o_valid, frame_err;
   logic [7:0] o;
   logic [2:0] s;
   logic       i_ready_m, o_valid_m, frame_err_m;
   logic [7:0] o_m;
   logic [2:0] s_m;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seq_1to8_demux #(.LSB_FIRST(1), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .i_ready(i_ready),
      .o(o), .o_valid(o_valid), .o_ready(o_ready), .s(s), .frame_err(frame_err));

   seq_1to8_demux #(.LSB_FIRST(0), .TIMEOUT(TO)) dut_m (
      .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .i_ready(i_ready_m),
      .o(o_m), .o_valid(o_valid_m), .o_ready(o_ready), .s(s_m), .frame_err(frame_err_m));

   // Reference model: frame bits collected in a queue, byte built arithmetically.
   bit         q[$];
   int         m_gap = 0;
   logic       m_ovalid = 1'b0;
   logic       m_err = 1'b0;
   logic [7:0] m_o_lsb = 8'h00;
   logic [7:0] m_o_msb = 8'h00;

   always @(posedge clk) begin
      int ones;
      int lsb, msb;
      if (rst) begin
         q.delete();
         m_gap = 0; m_ovalid = 1'b0; m_err = 1'b0;
         m_o_lsb = 8'h00; m_o_msb = 8'h00;
      end else begin
         m_err = 1'b0;
         if (m_ovalid) begin
            if (o_ready) m_ovalid = 1'b0;
         end else if (i_valid) begin
            q.push_back(i);
            m_gap = 0;
            if (q.size() == FRAME) begin
               ones = 0; lsb = 0; msb = 0;
               for (int k = 0; k < 8; k++) begin
                  if (q[k]) begin
                     ones++;
                     lsb += (1 << k);
                     msb += (1 << (7 - k));
                  end
               end
               if ((FRAME == 9) && ((ones % 2) != int'(q[FRAME-1]))) begin
                  m_err = 1'b1;
               end else begin
                  m_o_lsb = 8'(lsb);
                  m_o_msb = 8'(msb);
                  m_ovalid = 1'b1;
               end
               q.delete();
            end
         end else if (q.size() > 0) begin
            m_gap++;
            if (m_gap == TO) begin
               q.delete();
               m_gap = 0;
               m_err = 1'b1;
            end
         end
      end
   end

   function automatic logic [2:0] m_s();
      return (q.size() < 8) ? 3'(q.size()) : 3'd0;
   endfunction

   function automatic logic [7:0] rev8(input logic [7:0] d);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[k] = d[7-k];
      return r;
   endfunction

   task automatic step(input logic v, input logic b);
      i_valid = v;
      i = b;
      @(posedge clk);
      #1;
   endtask

   // Sends d LSB first (plus the parity bit, flipped when bad_par is set).
   task automatic send_byte(input logic [7:0] d, input logic bad_par);
      for (int k = 0; k < 8; k++) step(1'b1, d[k]);
      if (FRAME == 9) step(1'b1, (^d) ^ bad_par);
      i_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      n_checks++;
      if ({o, o_valid, s, frame_err, i_ready} !== {8'h00, 1'b0, 3'd0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_state: got o=%h ov=%b s=%0d fe=%b ir=%b, need 00 0 0 0 1", o, o_valid, s, frame_err, i_ready);
      end
      rst = 1'b0;
      step(1'b0, 1'b0);
   endtask

   task automatic test_basic_order();
      logic [7:0] seq;
      seq = 8'b0100_1101;  // bit k of seq is the k-th bit sent: 1,0,1,1,0,0,1,0
      o_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (s !== 3'(k) || s_m !== 3'(k) || i_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL slot_count: got s=%0d s_m=%0d ir=%b, need %0d 1", s, s_m, i_ready, k);
         end
         step(1'b1, seq[k]);
      end
      if (FRAME == 9) step(1'b1, ^seq);
      i_valid = 1'b0;
      n_checks++;
      if (o !== 8'h4D || o_valid !== 1'b1 || i_ready !== 1'b0 || s !== 3'd0) begin
         n_fail++;
         $display("FAIL lsb_first_byte: got o=%h ov=%b ir=%b s=%0d, need 4d 1 0 0", o, o_valid, i_ready, s);
      end
      n_checks++;
      if (o_m !== 8'hB2 || o_valid_m !== 1'b1) begin
         n_fail++;
         $display("FAIL msb_first_byte: got o=%h ov=%b, need b2 1", o_m, o_valid_m);
      end
      step(1'b0, 1'b0);
      n_checks++;
      if (o_valid !== 1'b0 || i_ready !== 1'b1 || o !== 8'h4D) begin
         n_fail++;
         $display("FAIL valid_one_cycle: got ov=%b ir=%b o=%h, need 0 1 4d", o_valid, i_ready, o);
      end
   endtask

   task automatic test_stall();
      logic [7:0] d1, d2;
      d1 = 8'($urandom);
      d2 = 8'($urandom);
      o_ready = 1'b0;
      send_byte(d1, 1'b0);
      for (int c = 0; c < 5; c++) begin
         n_checks++;
         if (o_valid !== 1'b1 || o !== d1 || o_m !== rev8(d1) || i_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold: cycle %0d got ov=%b o=%h om=%h ir=%b, need 1 %h %h 0", c, o_valid, o, o_m, i_ready, d1, rev8(d1));
         end
         step(1'b1, ~d1[0]);  // offered bits must be refused while full
      end
      o_ready = 1'b1;
      step(1'b0, 1'b0);
      n_checks++;
      if (o_valid !== 1'b0 || i_ready !== 1'b1 || s !== 3'd0) begin
         n_fail++;
         $display("FAIL stall_release: got ov=%b ir=%b s=%0d, need 0 1 0", o_valid, i_ready, s);
      end
      send_byte(d2, 1'b0);
      n_checks++;
      if (o_valid !== 1'b1 || o !== d2 || o_m !== rev8(d2)) begin
         n_fail++;
         $display("FAIL after_stall_frame: got ov=%b o=%h om=%h, need 1 %h %h", o_valid, o, o_m, d2, rev8(d2));
      end
      step(1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      logic [7:0] prev;
      prev = o;
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
      for (int c = 1; c <= 4; c++) begin
         step(1'b0, 1'b0);
         n_checks++;
         if (c < 4 && (frame_err !== 1'b0 || s !== 3'd3)) begin
            n_fail++;
            $display("FAIL timeout_early: idle %0d got fe=%b s=%0d, need 0 3", c, frame_err, s);
         end else if (c == 4 && (frame_err !== 1'b1 || frame_err_m !== 1'b1 || s !== 3'd0 || o !== prev || o_valid !== 1'b0)) begin
            n_fail++;
            $display("FAIL timeout_pulse: got fe=%b fem=%b s=%0d o=%h ov=%b, need 1 1 0 %h 0", frame_err, frame_err_m, s, o, o_valid, prev);
         end
      end
      step(1'b0, 1'b0);
      n_checks++;
      if (frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_one_cycle: got fe=%b, need 0", frame_err);
      end
      // Bit arriving on the 4th idle cycle rescues the frame.
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
      for (int c = 0; c < 3; c++) step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      n_checks++;
      if (frame_err !== 1'b0 || s !== 3'd4) begin
         n_fail++;
         $display("FAIL timeout_bit_wins: got fe=%b s=%0d, need 0 4", frame_err, s);
      end
      for (int k = 0; k < 4; k++) step(1'b1, 1'b1);
      if (FRAME == 9) step(1'b1, 1'b1);  // data 8'hF8 has odd weight
      i_valid = 1'b0;
      n_checks++;
      if (o_valid !== 1'b1 || o !== 8'hF8 || frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_rescued_byte: got ov=%b o=%h fe=%b, need 1 f8 0", o_valid, o, frame_err);
      end
      step(1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      d = 8'($urandom);
      for (int k = 0; k < 5; k++) step(1'b1, d[k]);
      rst = 1'b1;
      step(1'b0, 1'b0);
      rst = 1'b0;
      n_checks++;
      if (s !== 3'd0 || o_valid !== 1'b0 || frame_err !== 1'b0 || i_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid: got s=%0d ov=%b fe=%b ir=%b, need 0 0 0 1", s, o_valid, frame_err, i_ready);
      end
      send_byte(~d, 1'b0);
      n_checks++;
      if (o_valid !== 1'b1 || o !== ~d || o_m !== rev8(~d)) begin
         n_fail++;
         $display("FAIL reset_mid_frame: got ov=%b o=%h om=%h, need 1 %h %h", o_valid, o, o_m, ~d, rev8(~d));
      end
      step(1'b0, 1'b0);
   endtask

`ifdef DEMUX_PARITY_EN
   task automatic test_parity();
      logic [7:0] prev;
      send_byte(8'h4D, 1'b0);
      n_checks++;
      if (o_valid !== 1'b1 || o !== 8'h4D || frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL parity_good: got ov=%b o=%h fe=%b, need 1 4d 0", o_valid, o, frame_err);
      end
      step(1'b0, 1'b0);
      prev = o;
      send_byte(8'h4D, 1'b1);
      n_checks++;
      if (o_valid !== 1'b0 || frame_err !== 1'b1 || o !== prev) begin
         n_fail++;
         $display("FAIL parity_bad: got ov=%b fe=%b o=%h, need 0 1 %h", o_valid, frame_err, o, prev);
      end
      step(1'b0, 1'b0);
   endtask
`endif

   task automatic test_random();
      int p;
      for (int seg = 0; seg < 9; seg++) begin
         p = (seg % 3 == 0) ? 90 : ((seg % 3 == 1) ? 50 : 15);
         for (int c = 0; c < 60; c++) begin
            o_ready = ($urandom_range(0, 99) < 70);
            step(($urandom_range(0, 99) < p), 1'($urandom));
            n_checks++;
            if ({o, o_valid, i_ready, s, frame_err} !== {m_o_lsb, m_ovalid, ~m_ovalid, m_s(), m_err}) begin
               n_fail++;
               $display("FAIL random_lsb: got o=%h ov=%b ir=%b s=%0d fe=%b, need %h %b %b %0d %b",
                        o, o_valid, i_ready, s, frame_err, m_o_lsb, m_ovalid, ~m_ovalid, m_s(), m_err);
            end
            n_checks++;
            if ({o_m, o_valid_m, i_ready_m, s_m, frame_err_m} !== {m_o_msb, m_ovalid, ~m_ovalid, m_s(), m_err}) begin
               n_fail++;
               $display("FAIL random_msb: got o=%h ov=%b ir=%b s=%0d fe=%b, need %h %b %b %0d %b",
                        o_m, o_valid_m, i_ready_m, s_m, frame_err_m, m_o_msb, m_ovalid, ~m_ovalid, m_s(), m_err);
            end
         end
      end
      o_ready = 1'b1;
      i_valid = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_basic_order();
      test_stall();
      test_timeout();
      test_reset_mid();
`ifdef DEMUX_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
